// File: rtl/ahb_sram_slave64_if.sv
// AHB-Lite bus bundle between a 64-bit master and the SRAM responder.
interface ahb_sram_slave64_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave64.sv
// AHB-Lite 64-bit SRAM responder: programmable wait states, byte-lane writes,
// two-cycle ERROR response for oversized or misaligned transfers.
module ahb_sram_slave64 #(
    parameter int unsigned AW          = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_sram_slave64_if.slave   bus
);

    localparam int unsigned DEPTH     = 2 ** (AW - 3);
    localparam bit          HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    // Address-phase capture; only legal transfers ever reach the data path,
    // so two size bits are enough.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic          write;
    } xfer_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    xfer_t         xfer_q;
    logic          accept;
    logic          ready_state;
    logic          illegal;
    logic          hreadyout;
    logic          hresp;
    logic [63:0]   hrdata;
    logic [7:0]    span;
    logic [7:0]    lane_mask;
    logic          write_en;
    logic [AW-4:0] word_idx;
    logic [63:0]   mem [DEPTH];

    // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
    logic unused_bits;
    assign unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0]};

    // Size/alignment check on the incoming address phase.
    always_comb begin
        illegal = 1'b0;
        case (bus.HSIZE)
            3'd0:    illegal = 1'b0;
            3'd1:    illegal = bus.HADDR[0];
            3'd2:    illegal = |bus.HADDR[1:0];
            3'd3:    illegal = |bus.HADDR[2:0];
            default: illegal = 1'b1;
        endcase
    end

    // State, wait counter and address-phase capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                xfer_q.addr  <= bus.HADDR[AW-1:0];
                xfer_q.size  <= bus.HSIZE[1:0];
                xfer_q.write <= bus.HWRITE;
            end
        end
    end

    // Next state and Moore outputs; accepts only land in ready states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout   = 1'b1;
        hresp       = 1'b0;
        ready_state = 1'b0;

        case (state_q)
            S_IDLE, S_DATA: begin
                ready_state = 1'b1;
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp       = 1'b1;
                ready_state = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = ready_state & bus.HSEL & bus.HREADY & bus.HTRANS[1];

        if (ready_state) begin
            if (!accept) begin
                state_d = S_IDLE;
            end else if (illegal) begin
                state_d = S_ERR1;
            end else if (HAS_WAIT) begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    // Little-endian byte-lane enables for the captured transfer.
    always_comb begin
        case (xfer_q.size)
            2'd0:    span = 8'h01;
            2'd1:    span = 8'h03;
            2'd2:    span = 8'h0F;
            default: span = 8'hFF;
        endcase
        lane_mask = span << xfer_q.addr[2:0];
    end

    assign word_idx = xfer_q.addr[AW-1:3];
    assign write_en = (state_q == S_DATA) && xfer_q.write;

    // Write commit on the edge that ends the completion cycle; array is not reset.
    always_ff @(posedge HCLK) begin
        if (write_en) begin
            for (int b = 0; b < 8; b++) begin
                if (lane_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data straight from the array while a read is in its data phase.
    always_comb begin
        hrdata = 64'd0;
        if (((state_q == S_WAIT) || (state_q == S_DATA)) && !xfer_q.write) begin
            hrdata = mem[word_idx];
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = hrdata;

endmodule

// File: tb/tb_ahb_sram_slave64.sv
// Bench for ahb_sram_slave64: a zero-wait and a three-wait instance driven
// side by side, checked against a transaction-level model plus a vector table.
module tb_ahb_sram_slave64;

    localparam int unsigned AW = 12;
    localparam int          NW = 2 ** (AW - 3);

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_sram_slave64_if bus0 ();
    ahb_sram_slave64_if bus3 ();

    logic [1:0]  in_hsel;
    logic [1:0]  in_hwrite;
    logic [1:0]  in_htrans [2];
    logic [31:0] in_haddr  [2];
    logic [2:0]  in_hsize  [2];
    logic [63:0] in_hwdata [2];
    logic [1:0]  o_ready;
    logic [1:0]  o_resp;
    logic [63:0] o_rdata   [2];

    assign bus0.HSEL   = in_hsel[0];
    assign bus0.HTRANS = in_htrans[0];
    assign bus0.HADDR  = in_haddr[0];
    assign bus0.HSIZE  = in_hsize[0];
    assign bus0.HWRITE = in_hwrite[0];
    assign bus0.HWDATA = in_hwdata[0];
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus3.HSEL   = in_hsel[1];
    assign bus3.HTRANS = in_htrans[1];
    assign bus3.HADDR  = in_haddr[1];
    assign bus3.HSIZE  = in_hsize[1];
    assign bus3.HWRITE = in_hwrite[1];
    assign bus3.HWDATA = in_hwdata[1];
    assign bus3.HREADY = bus3.HREADYOUT;

    assign o_ready[0] = bus0.HREADYOUT;
    assign o_resp[0]  = bus0.HRESP;
    assign o_rdata[0] = bus0.HRDATA;
    assign o_ready[1] = bus3.HREADYOUT;
    assign o_resp[1]  = bus3.HRESP;
    assign o_rdata[1] = bus3.HRDATA;

    ahb_sram_slave64 #(.AW(AW), .WAIT_STATES(0)) dut0 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus0.slave)
    );

    ahb_sram_slave64 #(.AW(AW), .WAIT_STATES(3)) dut3 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus3.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fill_val(input int d, input int k);
        return {8'hA5, 8'(d), 8'(k), 40'h12_3456_789A};
    endfunction

    // Transaction-level reference: each accepted transfer occupies a data
    // phase of WS+1 cycles (OKAY) or 2 cycles (ERROR).
    int          ws [2] = '{0, 3};
    int          phase_left [2];
    bit          m_err   [2];
    bit          m_write [2];
    logic [31:0] m_addr  [2];
    int          m_size  [2];
    logic [63:0] mmem    [2][NW];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) phase_left[d] = 0;
    endtask

    task automatic model_exp(input int d, output logic r, output logic s, output logic [63:0] rd);
        r  = 1'b1;
        s  = 1'b0;
        rd = 64'd0;
        if (phase_left[d] > 0) begin
            r = (phase_left[d] == 1);
            if (m_err[d]) s = 1'b1;
            else if (!m_write[d]) rd = mmem[d][m_addr[d][AW-1:3]];
        end
    endtask

    task automatic model_step(input int d);
        logic        r, s;
        logic [63:0] rd, w;
        int          off, n;
        model_exp(d, r, s, rd);
        if (phase_left[d] > 0) begin
            if (phase_left[d] == 1 && !m_err[d] && m_write[d]) begin
                w   = mmem[d][m_addr[d][AW-1:3]];
                off = int'(m_addr[d][2:0]);
                n   = 1 << m_size[d];
                for (int b = off; b < off + n; b++) w[8*b +: 8] = in_hwdata[d][8*b +: 8];
                mmem[d][m_addr[d][AW-1:3]] = w;
            end
            phase_left[d]--;
        end
        if (r && in_hsel[d] && in_htrans[d][1]) begin
            m_addr[d]     = in_haddr[d];
            m_size[d]     = int'(in_hsize[d]);
            m_write[d]    = in_hwrite[d];
            m_err[d]      = (m_size[d] > 3) || ((in_haddr[d] % (1 << m_size[d])) != 0);
            phase_left[d] = m_err[d] ? 2 : ws[d] + 1;
        end
    endtask

    task automatic model_check(input int d);
        logic        r, s;
        logic [63:0] rd;
        model_exp(d, r, s, rd);
        chk($sformatf("model%0d.hreadyout", d), 64'(o_ready[d]), 64'(r));
        chk($sformatf("model%0d.hresp", d),     64'(o_resp[d]),  64'(s));
        chk($sformatf("model%0d.hrdata", d),    o_rdata[d],      rd);
    endtask

    task automatic set_in(input int d, input logic hsel, input logic [1:0] ht, input logic [31:0] a,
                          input logic [2:0] sz, input logic wr, input logic [63:0] wd);
        in_hsel[d]   = hsel;
        in_htrans[d] = ht;
        in_haddr[d]  = a;
        in_hsize[d]  = sz;
        in_hwrite[d] = wr;
        in_hwdata[d] = wd;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) set_in(d, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 64'd0);
    endtask

    // One bus cycle: model follows the edge, then both DUTs are checked.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(negedge HCLK);
        model_check(0);
        model_check(1);
    endtask

    typedef struct {
        int          d;
        logic        hsel;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [63:0] hwdata;
        logic        exp_ready;
        logic        exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input logic hsel, input logic [1:0] ht, input logic [31:0] a,
                       input logic [2:0] sz, input logic wr, input logic [63:0] wd,
                       input logic er, input logic es, input logic [63:0] erd);
        vec_t v;
        v.d = d; v.hsel = hsel; v.htrans = ht; v.haddr = a; v.hsize = sz;
        v.hwrite = wr; v.hwdata = wd; v.exp_ready = er; v.exp_resp = es; v.exp_rdata = erd;
        tbl.push_back(v);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        // Expected outputs of each row describe the cycle before its inputs are driven.
        add(0, 1, 2'd0, 32'h10,       3'd3, 0, 64'd0,                  1, 0, 64'd0);
        add(0, 1, 2'd1, 32'h10,       3'd3, 1, 64'd0,                  1, 0, 64'd0);
        add(0, 1, 2'd2, 32'h10,       3'd3, 1, 64'd0,                  1, 0, 64'd0);
        add(0, 1, 2'd2, 32'h10,       3'd3, 0, 64'h0123456789ABCDEF,   1, 0, 64'd0);
        add(0, 1, 2'd2, 32'h13,       3'd0, 1, 64'd0,                  1, 0, 64'h0123456789ABCDEF);
        add(0, 1, 2'd2, 32'h10,       3'd3, 0, 64'h11111111AA222222,   1, 0, 64'd0);
        add(0, 1, 2'd2, 32'h22,       3'd2, 1, 64'd0,                  1, 0, 64'h01234567AAABCDEF);
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, ONES,                   0, 1, 64'd0);
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, ONES,                   1, 1, 64'd0);
        add(0, 1, 2'd2, 32'h20,       3'd4, 1, 64'd0,                  1, 0, 64'd0);
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, ONES,                   0, 1, 64'd0);
        add(0, 1, 2'd2, 32'h20,       3'd3, 0, ONES,                   1, 1, 64'd0);
        add(0, 1, 2'd3, 32'hFFFFF010, 3'd2, 0, 64'd0,                  1, 0, fill_val(0, 4));
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  1, 0, 64'h01234567AAABCDEF);
        add(0, 0, 2'd2, 32'h10,       3'd3, 1, 64'd0,                  1, 0, 64'd0);
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, ONES,                   1, 0, 64'd0);
        add(0, 1, 2'd2, 32'h10,       3'd3, 0, 64'd0,                  1, 0, 64'd0);
        add(0, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  1, 0, 64'h01234567AAABCDEF);
        add(1, 1, 2'd2, 32'h10,       3'd3, 0, 64'd0,                  1, 0, 64'd0);
        add(1, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  0, 0, fill_val(1, 2));
        add(1, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  0, 0, fill_val(1, 2));
        add(1, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  0, 0, fill_val(1, 2));
        add(1, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  1, 0, fill_val(1, 2));
        add(1, 0, 2'd0, 32'h0,        3'd0, 0, 64'd0,                  1, 0, 64'd0);

        // Reset.
        idle_all();
        model_reset();
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d.hreadyout", d), 64'(o_ready[d]), 64'd1);
            chk($sformatf("reset%0d.hresp", d),     64'(o_resp[d]),  64'd0);
            chk($sformatf("reset%0d.hrdata", d),    o_rdata[d],      64'd0);
        end

        // Preload words 0..15 of both memories.
        for (int k = 0; k < 16; k++) begin
            for (int d = 0; d < 2; d++) set_in(d, 1'b1, 2'd2, 32'(k * 8), 3'd3, 1'b1, 64'd0);
            cycle();
            repeat (4) begin
                for (int d = 0; d < 2; d++) set_in(d, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, fill_val(d, k));
                cycle();
            end
        end

        // Directed vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("tbl%0d.hreadyout", i), 64'(o_ready[tbl[i].d]), 64'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d.hresp", i),     64'(o_resp[tbl[i].d]),  64'(tbl[i].exp_resp));
            chk($sformatf("tbl%0d.hrdata", i),    o_rdata[tbl[i].d],      tbl[i].exp_rdata);
            idle_all();
            set_in(tbl[i].d, tbl[i].hsel, tbl[i].htrans, tbl[i].haddr, tbl[i].hsize,
                   tbl[i].hwrite, tbl[i].hwdata);
            cycle();
        end

        // Reset asserted while a wait-state write is in flight.
        idle_all();
        set_in(1, 1'b1, 2'd2, 32'h18, 3'd3, 1'b1, 64'd0);
        cycle();
        idle_all();
        set_in(1, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        cycle();
        chk("rstwr.wait_hreadyout", 64'(o_ready[1]), 64'd0);
        chk("rstwr.wait_hrdata",    o_rdata[1],      64'd0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rstwr.async_hreadyout", 64'(o_ready[1]), 64'd1);
        chk("rstwr.async_hresp",     64'(o_resp[1]),  64'd0);
        chk("rstwr.async_hrdata",    o_rdata[1],      64'd0);
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_check(0);
        model_check(1);
        idle_all();
        set_in(1, 1'b1, 2'd2, 32'h18, 3'd3, 1'b0, 64'd0);
        cycle();
        idle_all();
        repeat (3) cycle();
        chk("rstwr.read_hreadyout", 64'(o_ready[1]), 64'd1);
        chk("rstwr.read_hrdata",    o_rdata[1],      fill_val(1, 3));

        // Random traffic against the model; inputs during stalls must be ignored.
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                int r;
                r            = int'($urandom_range(0, 9));
                in_hsel[d]   = ($urandom_range(0, 9) < 8);
                in_htrans[d] = 2'($urandom_range(0, 3));
                in_haddr[d]  = {20'($urandom), 5'd0, 7'($urandom)};
                in_hsize[d]  = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
                in_hwrite[d] = 1'($urandom);
                in_hwdata[d] = {$urandom, $urandom};
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
